// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer that clears a serial shift register, streams a word MSB-first and reassembles the returned bits.
// Latency: done pulses 1+WORD+DEPTH cycles after the start-acceptance edge.
// Backpressure: none. start is honoured only in IDLE and is not queued.
//
// Ports:
//   CLK, Reset              clock; synchronous active-high reset
//   start, tx_word          transfer request and parallel word (captured on acceptance)
//   busy, done              busy in CLEAR/SEND/FLUSH; one-cycle done pulse
//   rx_word, mismatch       reassembled word and TX/RX compare flag, held until next acceptance
//   sr_reset, sr_shift_in   drive the shift register's Reset and Shift_in
//   sr_shift_out            serial data returning from the shift register
module shift_reg_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int WORD  = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic [WORD-1:0] tx_word,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] rx_word,
  output logic            mismatch,
  output logic            sr_reset,
  output logic            sr_shift_in,
  input  logic            sr_shift_out
);

  localparam int CW = $clog2(WORD + DEPTH);

  // Counter landmarks across the combined SEND+FLUSH window.
  localparam logic [CW-1:0] SEND_LAST  = CW'(WORD - 1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(WORD + DEPTH - 1);
  localparam logic [CW-1:0] CAP_FIRST  = CW'(DEPTH);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]      state;
  logic [CW-1:0]   n;
  logic [WORD-1:0] tx_hold;
  logic [WORD-1:0] tx_sh;
  logic [WORD-1:0] rx_sh;
  logic [WORD-1:0] rx_next;

  // Shift-left-and-insert works for WORD=1 too: the shift empties the word.
  assign rx_next = (rx_sh << 1) | WORD'(sr_shift_out);

  assign busy        = (state == ST_CLEAR) || (state == ST_SEND) || (state == ST_FLUSH);
  assign done        = (state == ST_DONE);
  assign sr_reset    = Reset || (state == ST_CLEAR);
  assign sr_shift_in = (state == ST_SEND) && tx_sh[WORD-1];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      n        <= '0;
      tx_hold  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_word  <= '0;
      mismatch <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            tx_hold  <= tx_word;
            tx_sh    <= tx_word;
            rx_sh    <= '0;
            n        <= '0;
            rx_word  <= '0;
            mismatch <= 1'b0;
            state    <= ST_CLEAR;
          end
        end

        ST_CLEAR: begin
          state <= ST_SEND;
        end

        ST_SEND: begin
          tx_sh <= tx_sh << 1;
          // Bits driven at n=i come back at n=i+DEPTH, so capture may start inside SEND.
          if (n >= CAP_FIRST) begin
            rx_sh <= rx_next;
          end
          n <= n + 1'b1;
          if (n == SEND_LAST) begin
            state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          if (n >= CAP_FIRST) begin
            rx_sh <= rx_next;
          end
          if (n == FLUSH_LAST) begin
            // The final sample lands on this same edge, so publish from rx_next.
            state    <= ST_DONE;
            rx_word  <= rx_next;
            mismatch <= (rx_next != tx_hold);
          end else begin
            n <= n + 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl: directed plus randomized transfers against a cycle-offset reference.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_shift_reg_seq_ctrl;

  localparam int D = 4;
  localparam int W = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         Reset;
  logic         start;
  logic [W-1:0] tx_word;
  logic         busy, done, mismatch, sr_reset, sr_shift_in, sr_shift_out;
  logic [W-1:0] rx_word;

  // Second instance at the minimum legal size.
  logic       start2;
  logic [0:0] tx2;
  logic       busy2, done2, mm2, srr2, sri2, sro2;
  logic [0:0] rx2;

  shift_reg_seq_ctrl #(.DEPTH(D), .WORD(W)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .tx_word(tx_word),
    .busy(busy), .done(done), .rx_word(rx_word), .mismatch(mismatch),
    .sr_reset(sr_reset), .sr_shift_in(sr_shift_in), .sr_shift_out(sr_shift_out)
  );

  shift_reg_seq_ctrl #(.DEPTH(1), .WORD(1)) dut2 (
    .CLK(CLK), .Reset(Reset), .start(start2), .tx_word(tx2),
    .busy(busy2), .done(done2), .rx_word(rx2), .mismatch(mm2),
    .sr_reset(srr2), .sr_shift_in(sri2), .sr_shift_out(sro2)
  );

  // Attached serial shift registers with synchronous reset; the first can be overridden for one cycle.
  logic [D-1:0] sr_q;
  logic         force_en, force_val;
  logic         sr2_q;

  always @(posedge CLK) begin
    if (sr_reset) sr_q <= '0;
    else          sr_q <= {sr_q[D-2:0], sr_shift_in};
    if (srr2)     sr2_q <= 1'b0;
    else          sr2_q <= sri2;
  end

  assign sr_shift_out = force_en ? force_val : sr_q[D-1];
  assign sro2         = sr2_q;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] prev_rx;
  logic         prev_mm;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  // One transfer, cycle 0 = acceptance cycle. fc = cycle whose shift_out is forced to fv (-1: none).
  // With hold set, start stays high and tx_word shows hold_tx while the transfer runs.
  task automatic xfer(input logic [W-1:0] tx, input int fc, input logic fv,
                      input bit hold, input logic [W-1:0] hold_tx);
    logic [W-1:0] exp_rx;
    logic [3:0]   exp_ctl;
    logic         exp_si;
    int           k;
    exp_rx = tx;
    // Shift_out in cycle c carries the bit sent in cycle c-D, i.e. sample index c-2-D.
    if (fc >= 2 + D && fc <= 1 + D + W) begin
      k = fc - 2 - D;
      exp_rx[W-1-k] = fv;
    end
    for (int c = 0; c <= W + D + 1 + 1; c++) begin
      tick();
      if (c == 0) begin
        start = 1'b1; tx_word = tx;
      end else if (hold) begin
        start = 1'b1; tx_word = hold_tx;
      end else begin
        start = 1'($urandom_range(0, 1)); tx_word = W'($urandom);
      end
      force_en  = (c == fc);
      force_val = fv;
      at_neg();
      exp_si  = (c >= 2 && c <= W + 1) ? tx[W-1-(c-2)] : 1'b0;
      exp_ctl = {(c >= 1 && c <= W + D + 1), (c == W + D + 2), (c == 1), exp_si};
      check("ctl{busy,done,sr_reset,sr_shift_in}", {28'd0, busy, done, sr_reset, sr_shift_in},
            {28'd0, exp_ctl});
      if (c == 0) begin
        check("rx_word_held", {24'd0, rx_word}, {24'd0, prev_rx});
        check("mismatch_held", {31'd0, mismatch}, {31'd0, prev_mm});
      end
      if (c == 1) check("rx_clear_on_accept", {23'd0, mismatch, rx_word}, 32'd0);
      if (c == W + D + 2) begin
        check("rx_word", {24'd0, rx_word}, {24'd0, exp_rx});
        check("mismatch", {31'd0, mismatch}, {31'd0, (exp_rx != tx)});
        prev_rx = exp_rx;
        prev_mm = (exp_rx != tx);
      end
    end
    force_en = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      start    = 1'b0;
      tx_word  = W'($urandom);
      force_en = 1'b0;
      at_neg();
      check("idle_ctl", {28'd0, busy, done, sr_reset, sr_shift_in}, 32'd0);
      check("idle_rx", {23'd0, mismatch, rx_word}, {23'd0, prev_mm, prev_rx});
    end
  endtask

  // Start a transfer, then pulse Reset during cycle 6 (mid-SEND).
  task automatic reset_mid(input logic [W-1:0] tx);
    for (int c = 0; c <= 7; c++) begin
      tick();
      start   = (c == 0);
      tx_word = tx;
      Reset   = (c == 6);
      at_neg();
      if (c == 6) check("sr_reset_during_reset", {31'd0, sr_reset}, 32'd1);
      if (c == 7) check("after_abort", {22'd0, busy, done, sr_shift_in, mismatch, rx_word}, 32'd0);
    end
    prev_rx = '0;
    prev_mm = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; tx_word = '0;
    start2 = 1'b0; tx2 = '0;
    force_en = 1'b0; force_val = 1'b0;
    prev_rx = '0; prev_mm = 1'b0;
    tick();
    tick();
    at_neg();
    check("reset_outputs", {21'd0, busy, done, mismatch, sr_shift_in, rx_word}, 32'd0);
    check("reset_sr_reset", {31'd0, sr_reset}, 32'd1);
    check("reset_outputs2", {28'd0, busy2, done2, mm2, rx2}, 32'd0);
    tick();
    Reset = 1'b0;
    idle(2);

    xfer(8'hA5, -1, 1'b0, 1'b0, 8'h00);
    xfer(8'hA5, 7, 1'b1, 1'b0, 8'h00);
    idle(1);
    xfer(8'h3C, -1, 1'b0, 1'b1, 8'hFF);
    xfer(8'hFF, -1, 1'b0, 1'b0, 8'h00);
    idle(1);
    reset_mid(8'hAA);
    idle(3);
    xfer(8'h0F, -1, 1'b0, 1'b0, 8'h00);
    xfer(8'h00, -1, 1'b0, 1'b0, 8'h00);
    xfer(8'hFF, -1, 1'b0, 1'b0, 8'h00);

    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] rtx;
      int           rfc;
      rtx = W'($urandom);
      rfc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W + D + 2)) : -1;
      xfer(rtx, rfc, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), W'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // DEPTH=1, WORD=1: done in the 4th cycle after acceptance.
    for (int t = 0; t < 3; t++) begin
      logic v;
      v = (t != 1);
      tick();
      start2 = 1'b1; tx2 = v;
      at_neg();
      check("w1_accept_busy", {31'd0, busy2}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
        tick();
        start2 = 1'b0;
        at_neg();
        check("w1_busy_done", {30'd0, busy2, done2}, {30'd0, (c <= 3), (c == 4)});
        if (c == 2) check("w1_shift_in", {31'd0, sri2}, {31'd0, v});
        if (c == 4) check("w1_rx", {30'd0, mm2, rx2}, {30'd0, 1'b0, v});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_reg_seq_ctrl.md
Name: shift_reg_seq_ctrl

Overview:
Sequencing controller for the 4-bit serial shift register. It clears the register, then streams a parallel TX word into Shift_in MSB-first. It flushes the word through the register's depth and reassembles the bits returned on shift_out into an RX word. It sits between a parallel requester (start/word/done handshake) and the free-running shift register. It also flags any TX/RX mismatch for loopback self-test.

Parameters:
DEPTH, 4, stages in the attached shift register (latency Shift_in -> shift_out in clock edges); legal >= 1
WORD, 8, bits per transfer; legal >= 1

Ports:
CLK  input  1  single clock, all logic on posedge
Reset  input  1  synchronous, active-high reset
start  input  1  transfer request, sampled only in IDLE
tx_word  input  WORD  parallel data, captured on the cycle start is accepted
busy  output  1  high in CLEAR, SEND, FLUSH
done  output  1  one-cycle pulse in DONE state
rx_word  output  WORD  reassembled word, stable from DONE until next acceptance
mismatch  output  1  high from DONE until next acceptance if rx_word != captured tx_word
sr_reset  output  1  drives shift register Reset
sr_shift_in  output  1  drives shift register Shift_in
sr_shift_out  input  1  from shift register shift_out

Behaviour:
- Reset (Reset=1 at a posedge): state=IDLE; busy=0, done=0, rx_word=0, mismatch=0, sr_shift_in=0, counters=0. sr_shift_out is ignored during reset.
- sr_reset = Reset OR (state==CLEAR). This is combinational, so the register is cleared in the same edge whenever the controller is reset, including mid-transfer.
- States: IDLE, CLEAR, SEND, FLUSH, DONE.
- IDLE: if start=1, latch tx_word into tx_hold, clear rx shift reg and counter, go CLEAR. Otherwise stay.
- CLEAR: exactly 1 cycle, sr_reset=1, sr_shift_in=0, go SEND.
- SEND: exactly WORD cycles, index i=0..WORD-1. sr_shift_in = tx_hold[WORD-1-i] (MSB first). Then go FLUSH.
- FLUSH: exactly DEPTH cycles, sr_shift_in=0. Then go DONE.
- Single cycle counter n counts 0..WORD+DEPTH-1 across SEND+FLUSH.
- Capture: on each posedge ending a cycle with n in [DEPTH, DEPTH+WORD-1], rx <= {rx[WORD-2:0], sr_shift_out}. This gives exactly WORD samples; with WORD=1, rx <= sr_shift_out. Bit driven at n=i appears on sr_shift_out at n=i+DEPTH.
- DONE: 1 cycle. done=1, busy=0. rx_word is the assembled value. mismatch=(rx != tx_hold). Next state IDLE unconditionally.
- start outside IDLE (incl. DONE) is ignored. It is not queued.
- Transfer length from acceptance edge to done: 1+WORD+DEPTH cycles. Minimum start-to-start spacing is 3+WORD+DEPTH cycles.
- tx_word changes after acceptance have no effect.
- rx_word/mismatch update only on entering DONE. Both clear on acceptance of the next start.
- Counter width = clog2(WORD+DEPTH). No wrap beyond terminal count.
- Reset mid-operation: abort, no done pulse, all outputs return to reset values on that edge.

Test Plan:
- Loopback, DEPTH=4, WORD=8, tx_word=8'hA5, start high cycle 0 -> sr_reset=1 cycle 1; sr_shift_in=1,0,1,0,0,1,0,1 cycles 2..9; 0 cycles 10..13; busy=1 cycles 1..13; done=1 cycle 14 only; rx_word=8'hA5, mismatch=0.
- Bench forces sr_shift_out=1 during cycle 7 of the 8'hA5 transfer -> rx_word=8'hE5, mismatch=1 at cycle 14.
- start held high continuously with 8'h3C then tx_word changed to 8'hFF during busy -> second transfer accepted only in the IDLE cycle after DONE (cycle 15). First rx_word=8'h3C. Second transfer uses the value present at its acceptance.
- Reset=1 at cycle 6 mid-SEND -> sr_reset=1 that cycle; next cycle busy=0, rx_word=0, no done pulse. A following start with 8'h0F completes normally with rx_word=8'h0F.
- Edge values 8'h00 and 8'hFF back-to-back -> rx_word matches, mismatch=0 both times, exactly one done pulse each.
- DEPTH=1, WORD=1, tx_word=1'b1 -> done 3 cycles after acceptance, rx_word=1.
